// File: rtl/eth_rx_frame_fifo_pkg.sv
// eth_rx_fifo_pkg: shared types and helpers for the RX frame FIFO
// Contents:
//   wr_state_e      write-side frame FSM states
//   STAT_CNT_WIDTH  width of the optional frame counters
//   ram_word_width  RAM word width for a given tdata width ({tlast, tuser, tdata})
package eth_rx_fifo_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, DROP} wr_state_e;

    localparam int STAT_CNT_WIDTH = 32;

    function automatic int ram_word_width(input int data_width);
        return data_width + 2;
    endfunction

endpackage

// File: rtl/eth_rx_frame_fifo_sdp_ram.sv
// eth_fifo_sdp_ram: simple dual-port RAM with registered read, BRAM-inferable
// Ports:
//   clk_i                         clock for both ports
//   wr_en_i, wr_addr_i, wr_data_i write port
//   rd_en_i, rd_addr_i            read port; rd_data_o updates only when rd_en_i is high
//   rd_data_o                     registered read data
module eth_fifo_sdp_ram #(
    parameter int WIDTH      = 10,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward RX frame FIFO behind the 1G MAC (rx_clk domain)
// Ports:
//   rx_clk, rx_rst                 clock, asynchronous active-high reset
//   s_axis_*                       AXI-stream input from the MAC (tuser sampled on tlast)
//   m_axis_*                       AXI-stream output, committed frames only
//   status_overflow/bad/good_frame 1-cycle pulses per dropped/dropped/committed frame
//   fifo_level                     committed beats still held in the RAM
//   stat_good/bad/ovf_cnt          saturating frame counters
// Build option: define ETH_RX_FIFO_STATS_EN to implement the counters; otherwise they read 0.
module eth_rx_frame_fifo
    import eth_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 12,
    parameter int DROP_BAD_FRAME = 1,
    parameter int DROP_WHEN_FULL = 1
) (
    input  logic                      rx_clk,
    input  logic                      rx_rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tuser,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic                      status_overflow,
    output logic                      status_bad_frame,
    output logic                      status_good_frame,
    output logic [ADDR_WIDTH:0]       fifo_level,
    output logic [STAT_CNT_WIDTH-1:0] stat_good_cnt,
    output logic [STAT_CNT_WIDTH-1:0] stat_bad_cnt,
    output logic [STAT_CNT_WIDTH-1:0] stat_ovf_cnt
);

    localparam int                  WORD_W    = ram_word_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LAST_SLOT = DEPTH - 1'b1;

    wr_state_e           state_q;
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_cur_q, rd_ptr_q, rd_ptr_d;
    logic                good_q, bad_q, ovf_q;
    logic                s1_valid_q, s1_valid_d, m_valid_q, m_valid_d;
    logic [WORD_W-1:0]   m_word_q, m_word_d, ram_rdata;
    logic                full_cur, empty, accept, drop_ovf, wr_en, s2_ld, rd_en;

    assign full_cur      = (wr_ptr_cur_q - rd_ptr_q) == DEPTH;
    assign empty         = wr_ptr_q == rd_ptr_q;
    assign s_axis_tready = (DROP_WHEN_FULL != 0) || (!full_cur && !rx_rst);
    assign accept        = s_axis_tvalid && s_axis_tready;
    // A frame that has filled every slot but one without ending can never be
    // committed, so it is dropped here instead of stalling the MAC forever.
    assign drop_ovf      = full_cur || ((wr_ptr_cur_q - wr_ptr_q) == LAST_SLOT && !s_axis_tlast);
    assign wr_en         = accept && state_q != DROP && !full_cur;

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            wr_ptr_cur_q <= '0;
            good_q       <= 1'b0;
            bad_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            good_q <= 1'b0;
            bad_q  <= 1'b0;
            ovf_q  <= 1'b0;
            if (accept) begin
                if (state_q == DROP) begin
                    if (s_axis_tlast) state_q <= IDLE;
                end else if (drop_ovf) begin
                    wr_ptr_cur_q <= wr_ptr_q;
                    ovf_q        <= 1'b1;
                    state_q      <= s_axis_tlast ? IDLE : DROP;
                end else if (s_axis_tlast) begin
                    if (s_axis_tuser && DROP_BAD_FRAME != 0) begin
                        wr_ptr_cur_q <= wr_ptr_q;
                        bad_q        <= 1'b1;
                    end else begin
                        wr_ptr_cur_q <= wr_ptr_cur_q + 1'b1;
                        wr_ptr_q     <= wr_ptr_cur_q + 1'b1;
                        good_q       <= 1'b1;
                    end
                    state_q <= IDLE;
                end else begin
                    wr_ptr_cur_q <= wr_ptr_cur_q + 1'b1;
                    state_q      <= WRITE;
                end
            end
        end
    end

    eth_fifo_sdp_ram #(
        .WIDTH     (WORD_W),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk_i    (rx_clk),
        .wr_en_i  (wr_en),
        .wr_addr_i(wr_ptr_cur_q[ADDR_WIDTH-1:0]),
        .wr_data_i({s_axis_tlast, s_axis_tuser && s_axis_tlast, s_axis_tdata}),
        .rd_en_i  (rd_en),
        .rd_addr_i(rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o(ram_rdata)
    );

    // Two-stage read pipe: the RAM's registered read feeds the output register,
    // each advancing whenever the stage after it is free or draining.
    assign s2_ld = s1_valid_q && (!m_valid_q || m_axis_tready);
    assign rd_en = !empty && (!s1_valid_q || s2_ld);

    always_comb begin
        rd_ptr_d   = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_en};
        s1_valid_d = rd_en || (s1_valid_q && !s2_ld);
        m_valid_d  = s2_ld || (m_valid_q && !m_axis_tready);
        m_word_d   = s2_ld ? ram_rdata : m_word_q;
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            rd_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_word_q   <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            s1_valid_q <= s1_valid_d;
            m_valid_q  <= m_valid_d;
            m_word_q   <= m_word_d;
        end
    end

    assign m_axis_tvalid     = m_valid_q;
    assign m_axis_tdata      = m_word_q[DATA_WIDTH-1:0];
    assign m_axis_tuser      = m_word_q[DATA_WIDTH] && (DROP_BAD_FRAME == 0);
    assign m_axis_tlast      = m_word_q[DATA_WIDTH+1];
    assign status_good_frame = good_q;
    assign status_bad_frame  = bad_q;
    assign status_overflow   = ovf_q;
    assign fifo_level        = wr_ptr_q - rd_ptr_q;

`ifdef ETH_RX_FIFO_STATS_EN
    logic [STAT_CNT_WIDTH-1:0] good_cnt_q, bad_cnt_q, ovf_cnt_q;

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            if (good_q && !(&good_cnt_q)) good_cnt_q <= good_cnt_q + 1'b1;
            if (bad_q && !(&bad_cnt_q)) bad_cnt_q <= bad_cnt_q + 1'b1;
            if (ovf_q && !(&ovf_cnt_q)) ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

    assign stat_good_cnt = good_cnt_q;
    assign stat_bad_cnt  = bad_cnt_q;
    assign stat_ovf_cnt  = ovf_cnt_q;
`else
    assign stat_good_cnt = '0;
    assign stat_bad_cnt  = '0;
    assign stat_ovf_cnt  = '0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb_eth_rx_frame_fifo: randomized frame traffic against a frame-queue model
module tb_eth_rx_frame_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  a_tdata = '0, a_mdata;
    logic        a_tvalid = 1'b0, a_tready, a_tlast = 1'b0, a_tuser = 1'b0;
    logic        a_mvalid, a_mready, a_mlast, a_muser, a_ovf, a_bad, a_good;
    logic [7:0]  a_level;
    logic [31:0] a_sg, a_sb, a_so;

    logic [7:0]  c_tdata = '0, c_mdata;
    logic        c_tvalid = 1'b0, c_tready, c_tlast = 1'b0, c_tuser = 1'b0;
    logic        c_mvalid, c_mready = 1'b1, c_mlast, c_muser, c_ovf, c_bad, c_good;
    logic [4:0]  c_level;
    logic [31:0] c_sg, c_sb, c_so;

    eth_rx_frame_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .DROP_BAD_FRAME(1), .DROP_WHEN_FULL(1)) dut_a (
        .rx_clk(clk), .rx_rst(rst),
        .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready),
        .s_axis_tlast(a_tlast), .s_axis_tuser(a_tuser),
        .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready),
        .m_axis_tlast(a_mlast), .m_axis_tuser(a_muser),
        .status_overflow(a_ovf), .status_bad_frame(a_bad), .status_good_frame(a_good),
        .fifo_level(a_level), .stat_good_cnt(a_sg), .stat_bad_cnt(a_sb), .stat_ovf_cnt(a_so)
    );

    eth_rx_frame_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DROP_BAD_FRAME(1), .DROP_WHEN_FULL(0)) dut_c (
        .rx_clk(clk), .rx_rst(rst),
        .s_axis_tdata(c_tdata), .s_axis_tvalid(c_tvalid), .s_axis_tready(c_tready),
        .s_axis_tlast(c_tlast), .s_axis_tuser(c_tuser),
        .m_axis_tdata(c_mdata), .m_axis_tvalid(c_mvalid), .m_axis_tready(c_mready),
        .m_axis_tlast(c_mlast), .m_axis_tuser(c_muser),
        .status_overflow(c_ovf), .status_bad_frame(c_bad), .status_good_frame(c_good),
        .fifo_level(c_level), .stat_good_cnt(c_sg), .stat_bad_cnt(c_sb), .stat_ovf_cnt(c_so)
    );

    int checks = 0, errors = 0;
    logic [8:0] qa[$], qc[$];
    int a_good_exp = 0, a_bad_exp = 0, a_ovf_exp = 0, a_good_seen = 0, a_bad_seen = 0, a_ovf_seen = 0;
    int c_good_exp = 0, c_bad_exp = 0, c_ovf_exp = 0, c_good_seen = 0, c_bad_seen = 0, c_ovf_seen = 0;
    int a_out_cnt = 0;
    bit a_rnd = 1'b0, a_fix = 1'b1;
    bit a_stall = 1'b0, c_stall = 1'b0;
    logic [9:0] a_held, c_held;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    initial begin
        a_mready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_mready = a_rnd ? ($urandom_range(99) < 75) : a_fix;
        end
    end

    always @(negedge clk) begin
        if (rst) a_stall = 1'b0;
        else begin
            if (a_stall) chk("a_hold", {a_mvalid, a_mlast, a_mdata}, a_held);
            if (a_mvalid) chk("a_tuser", a_muser, 0);
            if (a_mvalid && a_mready) begin
                chk("a_beat_expected", qa.size() != 0, 1);
                if (qa.size() != 0) chk("a_beat", {a_mlast, a_mdata}, qa.pop_front());
                a_out_cnt++;
            end
            a_stall = a_mvalid && !a_mready;
            a_held = {1'b1, a_mlast, a_mdata};
            a_good_seen += int'(a_good);
            a_bad_seen += int'(a_bad);
            a_ovf_seen += int'(a_ovf);
        end
    end

    always @(negedge clk) begin
        if (rst) c_stall = 1'b0;
        else begin
            if (c_stall) chk("c_hold", {c_mvalid, c_mlast, c_mdata}, c_held);
            if (c_mvalid) chk("c_tuser", c_muser, 0);
            if (c_mvalid && c_mready) begin
                chk("c_beat_expected", qc.size() != 0, 1);
                if (qc.size() != 0) chk("c_beat", {c_mlast, c_mdata}, qc.pop_front());
            end
            c_stall = c_mvalid && !c_mready;
            c_held = {1'b1, c_mlast, c_mdata};
            c_good_seen += int'(c_good);
            c_bad_seen += int'(c_bad);
            c_ovf_seen += int'(c_ovf);
        end
    end

    // Sends one frame; fits=0 means the model expects it to be dropped for overflow.
    task automatic send(input bit c, input int len, input bit user, input bit fits, input int gap);
        logic [8:0] fr[$];
        logic [7:0] d;
        logic l, u, acc;
        int n = 0, w = 0;
        while (n < len && w < 2000) begin
            if ($urandom_range(99) < gap) begin
                if (c) c_tvalid = 1'b0; else a_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end else begin
                d = 8'($urandom);
                l = (n == len - 1);
                u = l ? user : 1'($urandom);
                if (c) {c_tvalid, c_tlast, c_tuser, c_tdata} = {1'b1, l, u, d};
                else {a_tvalid, a_tlast, a_tuser, a_tdata} = {1'b1, l, u, d};
                @(negedge clk);
                acc = c ? c_tready : a_tready;
                @(posedge clk);
                #1;
                w++;
                if (acc) begin
                    fr.push_back({l, d});
                    n++;
                    w = 0;
                    if (c && n == 16 && len > 16) chk("c_ovf_at_beat16", c_ovf, 1);
                end
            end
        end
        if (n < len) chk("tready_stall", n, len);
        if (c) c_tvalid = 1'b0; else a_tvalid = 1'b0;
        if (!fits) begin
            if (c) c_ovf_exp++; else a_ovf_exp++;
        end else if (user) begin
            if (c) c_bad_exp++; else a_bad_exp++;
        end else begin
            if (c) c_good_exp++; else a_good_exp++;
            foreach (fr[i]) if (c) qc.push_back(fr[i]); else qa.push_back(fr[i]);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20000 && (qa.size() != 0 || qc.size() != 0); i++) @(posedge clk);
        #1;
        chk("drain", qa.size() + qc.size(), 0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic wait_room(input int len);
        int i = 0;
        while (int'(a_level) + len > 128 && i < 20000) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("room", int'(a_level) + len <= 128, 1);
    endtask

    task automatic counts();
        chk("a_good_cnt", a_good_seen, a_good_exp);
        chk("a_bad_cnt", a_bad_seen, a_bad_exp);
        chk("a_ovf_cnt", a_ovf_seen, a_ovf_exp);
        chk("c_good_cnt", c_good_seen, c_good_exp);
        chk("c_bad_cnt", c_bad_seen, c_bad_exp);
        chk("c_ovf_cnt", c_ovf_seen, c_ovf_exp);
    endtask

    task automatic check_reset_outputs(input string n);
        chk({n, "_a_out"}, {a_mvalid, a_mlast, a_muser, a_mdata, a_ovf, a_bad, a_good, a_level}, 0);
        chk({n, "_a_stats"}, {a_sg, a_sb, a_so}, 0);
        chk({n, "_a_tready"}, a_tready, 1);
        chk({n, "_c_out"}, {c_mvalid, c_mlast, c_muser, c_mdata, c_ovf, c_bad, c_good, c_level}, 0);
        chk({n, "_c_stats"}, {c_sg, c_sb, c_so}, 0);
    endtask

    initial begin
        int len;
        bit user;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        chk("reset_c_tready", c_tready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("c_tready_after_reset", c_tready, 1);

        send(0, 64, 0, 1, 0);
        chk("t1_level", a_level, 64);
        chk("t1_lat_n", a_mvalid, 0);
        @(posedge clk);
        #1;
        chk("t1_lat_n1", a_mvalid, 0);
        @(posedge clk);
        #1;
        chk("t1_lat_n2", a_mvalid, 1);
        drain();
        chk("t1_good", a_good_seen, 1);
        chk("t1_out", a_out_cnt, 64);

        send(0, 20, 1, 1, 0);
        chk("t2_level", a_level, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("t2_bad", a_bad_seen, 1);
        chk("t2_no_out", a_mvalid, 0);

        a_fix = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(0, 100, 0, 1, 0);
        chk("t3_level", a_level, 100);
        send(0, 100, 0, 0, 0);
        chk("t3_ovf", a_ovf_seen, 1);
        a_fix = 1'b1;
        drain();
        chk("t3_out", a_out_cnt, 164);

        send(1, 20, 0, 0, 0);
        send(1, 5, 0, 1, 0);
        drain();
        chk("t4_ovf", c_ovf_seen, 1);
        chk("t4_good", c_good_seen, 1);
        counts();

        a_rnd = 1'b1;
        for (int f = 0; f < 10; f++) begin
            wait_room(100);
            send(0, 100, 0, 1, 0);
        end
        drain();
        counts();

        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 40);
            user = ($urandom_range(99) < 25);
            wait_room(len);
            send(0, len, user, 1, 30);
        end
        drain();
        counts();

        a_rnd = 1'b0;
        a_fix = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(0, 10, 0, 1, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_out_pending", a_mvalid, 1);
        for (int i = 0; i < 7; i++) begin
            {a_tvalid, a_tlast, a_tuser, a_tdata} = {1'b1, 1'b0, 1'b0, 8'($urandom)};
            @(posedge clk);
            #1;
        end
        #3;
        rst = 1'b1;
        a_tvalid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        qa.delete();
        qc.delete();
        {a_good_exp, a_bad_exp, a_ovf_exp, a_good_seen, a_bad_seen, a_ovf_seen} = '0;
        {c_good_exp, c_bad_exp, c_ovf_exp, c_good_seen, c_bad_seen, c_ovf_seen} = '0;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst_next");
        rst = 1'b0;
        a_fix = 1'b1;
        @(posedge clk);
        #1;
        send(0, 30, 0, 1, 0);
        drain();
        chk("t6_good", a_good_seen, 1);
        counts();

`ifdef ETH_RX_FIFO_STATS_EN
        chk("a_stat_good", a_sg, a_good_exp);
        chk("a_stat_bad", a_sb, a_bad_exp);
        chk("a_stat_ovf", a_so, a_ovf_exp);
`else
        chk("a_stat_good", a_sg, 0);
        chk("a_stat_bad", a_sb, 0);
        chk("a_stat_ovf", a_so, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
